// File: rtl/mmcm_phase_seq.sv
`timescale 1ns/1ps
// mmcm_phase_seq: walks an MMCM/PLL dynamic phase shifter towards a requested
// phase one PSEN/PSDONE handshake at a time. It supports a linear signed phase
// or a modular phase with shortest-path direction, and raises a sticky error
// on rejected writes, lost lock and PSDONE timeouts.
module mmcm_phase_seq #(
    parameter int PHASE_WIDTH    = 8,
    parameter int PHASE_PERIOD   = 0,
    parameter int PSDONE_TIMEOUT = 31
) (
    input  logic                   psclk,
    input  logic                   rstn,
    input  logic                   locked,
    input  logic                   ps_we,
    input  logic                   ps_rel,
    input  logic [PHASE_WIDTH-1:0] ps_din,
    output logic                   ps_ready,
    output logic [PHASE_WIDTH-1:0] ps_dout,
    output logic                   ps_err,
    output logic                   psen,
    output logic                   psincdec,
    input  logic                   psdone
);

    localparam int W    = PHASE_WIDTH;
    // A zero period would make the modular helpers divide by zero; they are
    // unused in linear mode, so any non-zero stand-in is fine.
    localparam int PMOD = (PHASE_PERIOD > 0) ? PHASE_PERIOD : 1;
    localparam logic signed [W+1:0] PM    = (W+2)'(PMOD);
    localparam logic signed [W+1:0] PHALF = (W+2)'(PMOD / 2);
    localparam logic [W-1:0]        PLAST = W'(PMOD - 1);
    localparam int TW = (PSDONE_TIMEOUT > 1) ? $clog2(PSDONE_TIMEOUT) : 1;
    localparam logic [TW-1:0]       TLAST = TW'(PSDONE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_STEP = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [W-1:0]    r_target, w_target_nxt;
    logic [W-1:0]    r_dout, w_dout_nxt;
    logic            r_psen, w_psen_nxt;
    logic            r_incdec, w_incdec_nxt;
    logic            r_err, w_err_nxt;
    logic [TW-1:0]   r_tmo, w_tmo_nxt;

    logic signed [W+1:0] w_rel_sum;
    logic [W-1:0]        w_rel_target;
    logic signed [W:0]   w_diff_lin;
    logic signed [W+1:0] w_diff_mod;
    logic signed [W+1:0] w_dm;
    logic                w_inc;
    logic                w_bad_abs;
    logic                w_accept;

    // Reduce a signed sum into 0..PERIOD-1 (the % result takes the dividend's sign).
    function automatic logic [W-1:0] mod_wrap(input logic signed [W+1:0] v);
        logic signed [W+1:0] m;
        m = v % PM;
        if (m < 0) m = m + PM;
        return m[W-1:0];
    endfunction

    // Phase after one completed step, wrapping at the period in modular mode.
    function automatic logic [W-1:0] step_phase(input logic [W-1:0] p, input logic inc);
        if (inc) begin
            if (PHASE_PERIOD > 0 && p == PLAST) return '0;
            return p + 1'b1;
        end
        if (PHASE_PERIOD > 0 && p == '0) return PLAST;
        return p - 1'b1;
    endfunction

    assign ps_ready = (r_state == S_IDLE) && locked;
    assign ps_dout  = r_dout;
    assign ps_err   = r_err;
    assign psen     = r_psen;
    assign psincdec = r_incdec;

    assign w_accept     = ps_we && ps_ready;
    assign w_rel_sum    = $signed({2'b00, r_dout}) + $signed({{2{ps_din[W-1]}}, ps_din});
    assign w_rel_target = (PHASE_PERIOD > 0) ? mod_wrap(w_rel_sum) : w_rel_sum[W-1:0];
    assign w_diff_lin   = $signed({r_target[W-1], r_target}) - $signed({r_dout[W-1], r_dout});
    assign w_diff_mod   = $signed({2'b00, r_target}) - $signed({2'b00, r_dout});
    assign w_dm         = (w_diff_mod < 0) ? w_diff_mod + PM : w_diff_mod;
    // Modular mode takes the shorter way round, ties going up.
    assign w_inc        = (PHASE_PERIOD > 0) ? (w_dm <= PHALF) : (w_diff_lin > 0);
    assign w_bad_abs    = (PHASE_PERIOD > 0) && !ps_rel && ($signed({2'b00, ps_din}) >= PM);

    // Next-state and next-register values; every register holds by default and psen drops.
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_dout_nxt   = r_dout;
        w_psen_nxt   = 1'b0;
        w_incdec_nxt = r_incdec;
        w_err_nxt    = r_err;
        w_tmo_nxt    = r_tmo;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_bad_abs) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_err_nxt    = 1'b0;
                        w_target_nxt = ps_rel ? w_rel_target : ps_din;
                        w_state_nxt  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (!locked) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_target == r_dout) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_psen_nxt   = 1'b1;
                    w_incdec_nxt = w_inc;
                    w_state_nxt  = S_STEP;
                end
            end
            S_STEP: begin
                if (!locked) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!locked) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (psdone) begin
                    w_dout_nxt  = step_phase(r_dout, r_incdec);
                    w_state_nxt = S_CALC;
                end else if (r_tmo == TLAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge psclk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Phase, target, handshake outputs, error flag and PSDONE timeout counter.
    always_ff @(posedge psclk or negedge rstn) begin
        if (!rstn) begin
            r_target <= '0;
            r_dout   <= '0;
            r_psen   <= 1'b0;
            r_incdec <= 1'b0;
            r_err    <= 1'b0;
            r_tmo    <= '0;
        end else begin
            r_target <= w_target_nxt;
            r_dout   <= w_dout_nxt;
            r_psen   <= w_psen_nxt;
            r_incdec <= w_incdec_nxt;
            r_err    <= w_err_nxt;
            r_tmo    <= w_tmo_nxt;
        end
    end

endmodule
